// File: rtl/pixel_word_packer.sv
// pixel_word_packer
// Sits after the camera capture/normalisation stage. Each accepted 9-bit pixel
// is zero-extended into a 16-bit lane, and 16 lanes are collected into one
// 256-bit word. A 28x28 frame (784 pixels) therefore produces 49 words, which
// are written to consecutive DMEM addresses starting at BASE_ADDR. The block
// arms once per CPU enable period. It then holds img_done until the CPU drops
// enable.
//
// Ports
//   CLOCK_50     system clock, every register is posedge
//   rst_n        asynchronous active-low reset
//   enable       CPU request: capture and pack one image while high
//   frame_start  one-cycle pulse, the first pixel of a new frame follows
//   pxl_valid    pxl_data carries a pixel this cycle
//   pxl_data     normalised pixel
//   dmem_wren    DMEM write strobe, one cycle per completed word
//   dmem_wraddr  DMEM word address of the current write
//   dmem_wrdata  packed word; it changes only when a word completes
//   img_done     level: all pixels of the image have been written
//   busy         high while ARMED or FILL

module pixel_word_packer #(
   parameter int PXL_W         = 9,
   parameter int LANE_W        = 16,
   parameter int PXLS_PER_WORD = 16,
   parameter int NUM_PXLS      = 784,
   parameter int ADDR_W        = 7,
   parameter int BASE_ADDR     = 0
) (
   input  logic                              CLOCK_50,
   input  logic                              rst_n,
   input  logic                              enable,
   input  logic                              frame_start,
   input  logic                              pxl_valid,
   input  logic [PXL_W-1:0]                  pxl_data,
   output logic                              dmem_wren,
   output logic [ADDR_W-1:0]                 dmem_wraddr,
   output logic [LANE_W*PXLS_PER_WORD-1:0]   dmem_wrdata,
   output logic                              img_done,
   output logic                              busy
);

   localparam int WORD_W  = LANE_W * PXLS_PER_WORD;
   localparam int LANE_IW = $clog2(PXLS_PER_WORD);
   localparam int CNT_W   = $clog2(NUM_PXLS);

   localparam logic [LANE_IW-1:0] LAST_LANE = LANE_IW'(PXLS_PER_WORD - 1);
   localparam logic [CNT_W-1:0]   LAST_PXL  = CNT_W'(NUM_PXLS - 1);
   localparam logic [ADDR_W-1:0]  BASE      = ADDR_W'(BASE_ADDR);

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      FILL,
      DONE
   } state_t;

   state_t              state_q,   state_d;
   logic [CNT_W-1:0]    count_q,   count_d;
   logic [LANE_IW-1:0]  lane_q,    lane_d;
   logic [WORD_W-1:0]   fill_q,    fill_d;
   logic [ADDR_W-1:0]   addr_q,    addr_d;
   logic                wren_q,    wren_d;
   logic [ADDR_W-1:0]   wraddr_q,  wraddr_d;
   logic [WORD_W-1:0]   wrdata_q,  wrdata_d;
   logic                done_q,    done_d;
   logic [WORD_W-1:0]   word;

   // State register plus all datapath registers. Reset is asynchronous, so a
   // write that is registered but not yet seen is dropped at once.
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         count_q  <= '0;
         lane_q   <= '0;
         fill_q   <= '0;
         addr_q   <= BASE;
         wren_q   <= 1'b0;
         wraddr_q <= BASE;
         wrdata_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         lane_q   <= lane_d;
         fill_q   <= fill_d;
         addr_q   <= addr_d;
         wren_q   <= wren_d;
         wraddr_q <= wraddr_d;
         wrdata_q <= wrdata_d;
         done_q   <= done_d;
      end
   end

   // Next-state and datapath logic. The write strobe defaults low, so it lasts
   // a single cycle. A write registered on the previous edge still reaches
   // DMEM, even if enable falls in the same cycle. Whenever we restart or
   // abort, the fill register is cleared so that no partial word can leak
   // into a later write.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      lane_d   = lane_q;
      fill_d   = fill_q;
      addr_d   = addr_q;
      wren_d   = 1'b0;
      wraddr_d = wraddr_q;
      wrdata_d = wrdata_q;
      done_d   = done_q;
      word     = fill_q;

      case (state_q)
         IDLE: begin
            if (enable && !done_q) begin
               state_d = ARMED;
            end
         end

         ARMED: begin
            if (!enable) begin
               state_d = IDLE;
            end else if (frame_start) begin
               state_d = FILL;
               count_d = '0;
               lane_d  = '0;
               addr_d  = BASE;
               fill_d  = '0;
            end
         end

         FILL: begin
            if (!enable) begin
               state_d = IDLE;
               count_d = '0;
               lane_d  = '0;
               fill_d  = '0;
            end else if (frame_start) begin
               // A new frame starts over at the first address. Any pixel
               // presented in this same cycle is dropped.
               count_d = '0;
               lane_d  = '0;
               addr_d  = BASE;
               fill_d  = '0;
            end else if (pxl_valid) begin
               word[lane_q*LANE_W +: LANE_W] = LANE_W'(pxl_data);
               fill_d  = word;
               count_d = count_q + 1'b1;
               lane_d  = lane_q + 1'b1;
               if (lane_q == LAST_LANE) begin
                  wren_d   = 1'b1;
                  wraddr_d = addr_q;
                  wrdata_d = word;
                  addr_d   = addr_q + 1'b1;
                  lane_d   = '0;
                  fill_d   = '0;
               end
               // The frame holds a whole number of words, so the last pixel is
               // always a lane-15 pixel. img_done therefore rises together
               // with the final write strobe.
               if (count_q == LAST_PXL) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end
         end

         DONE: begin
            if (!enable) begin
               state_d = IDLE;
               done_d  = 1'b0;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign dmem_wren   = wren_q;
   assign dmem_wraddr = wraddr_q;
   assign dmem_wrdata = wrdata_q;
   assign img_done    = done_q;
   assign busy        = (state_q == ARMED) || (state_q == FILL);

endmodule

// File: tb/tb_pixel_word_packer.sv
// Directed testbench for pixel_word_packer. It drives the reset, full-frame,
// gapped-frame, restart, abort, done-hold and mid-frame reset scenarios.

module tb_pixel_word_packer;

   localparam int ADDR_W = 7;
   localparam int WORD_W = 256;

   logic                CLOCK_50 = 1'b0;
   logic                rst_n;
   logic                enable;
   logic                frameStart;
   logic                pxlValid;
   logic [8:0]          pxlData;
   logic                dmem_wren;
   logic [ADDR_W-1:0]   dmem_wraddr;
   logic [WORD_W-1:0]   dmem_wrdata;
   logic                img_done;
   logic                busy;

   int checks  = 0;
   int errors  = 0;
   int wrCount = 0;

   pixel_word_packer dut (
      .CLOCK_50    (CLOCK_50),
      .rst_n       (rst_n),
      .enable      (enable),
      .frame_start (frameStart),
      .pxl_valid   (pxlValid),
      .pxl_data    (pxlData),
      .dmem_wren   (dmem_wren),
      .dmem_wraddr (dmem_wraddr),
      .dmem_wrdata (dmem_wrdata),
      .img_done    (img_done),
      .busy        (busy)
   );

   // 50 MHz clock.
   always #10 CLOCK_50 = ~CLOCK_50;

   // Count write strobes on the falling edge, well away from the active edge.
   always @(negedge CLOCK_50) begin
      if (dmem_wren === 1'b1) wrCount++;
   end

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic check(input string tag, input logic [WORD_W-1:0] observed,
                        input logic [WORD_W-1:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Expected packed word w for a frame whose pixel i carries (i+offset) mod 512.
   function automatic logic [WORD_W-1:0] expWord(input int w, input int offset);
      logic [WORD_W-1:0] r;
      r = '0;
      for (int k = 0; k < 16; k++) begin
         r[k*16 +: 16] = 16'((w*16 + k + offset) % 512);
      end
      return r;
   endfunction

   task automatic pulseFrameStart();
      frameStart = 1'b1;
      step();
      frameStart = 1'b0;
   endtask

   // Send n pixels, optionally with an idle cycle after each one. After each
   // pixel, check the write strobe, address and data, plus img_done.
   task automatic applyStimulus(input int n, input int offset, input bit gap);
      for (int i = 0; i < n; i++) begin
         pxlValid = 1'b1;
         pxlData  = 9'((i + offset) % 512);
         step();
         check("wren", 256'(dmem_wren), 256'(i % 16 == 15));
         if (i % 16 == 15) begin
            check("wraddr", 256'(dmem_wraddr), 256'(i / 16));
            check("wrdata", dmem_wrdata, expWord(i / 16, offset));
         end
         check("img_done", 256'(img_done), 256'(i == 783));
         if (gap) begin
            pxlValid = 1'b0;
            step();
            check("wren gap", 256'(dmem_wren), 256'(1'b0));
         end
      end
      pxlValid = 1'b0;
   endtask

   task automatic rearm();
      enable = 1'b0;
      step();
      enable = 1'b1;
      step();
   endtask

   initial begin
      rst_n      = 1'b0;
      enable     = 1'b0;
      frameStart = 1'b0;
      pxlValid   = 1'b0;
      pxlData    = '0;
      #25;
      check("rst wren",   256'(dmem_wren),   256'(1'b0));
      check("rst wraddr", 256'(dmem_wraddr), 256'(0));
      check("rst wrdata", dmem_wrdata,       256'(0));
      check("rst done",   256'(img_done),    256'(1'b0));
      check("rst busy",   256'(busy),        256'(1'b0));
      rst_n = 1'b1;
      step();

      $display("[TB] full back-to-back frame");
      enable = 1'b1;
      step();
      check("armed busy", 256'(busy), 256'(1'b1));
      pulseFrameStart();
      wrCount = 0;
      applyStimulus(784, 0, 1'b0);
      step();
      check("t1 writes", 256'(wrCount), 256'(49));
      check("t1 busy",   256'(busy),    256'(1'b0));
      check("t1 done",   256'(img_done), 256'(1'b1));

      $display("[TB] gapped frame");
      enable = 1'b0;
      step();
      check("t2 done clr", 256'(img_done), 256'(1'b0));
      enable = 1'b1;
      step();
      pulseFrameStart();
      wrCount = 0;
      applyStimulus(784, 0, 1'b1);
      step();
      check("t2 writes", 256'(wrCount), 256'(49));

      $display("[TB] restart mid-frame");
      rearm();
      pulseFrameStart();
      wrCount = 0;
      applyStimulus(100, 300, 1'b0);
      step();
      check("t3 partial writes", 256'(wrCount), 256'(6));
      frameStart = 1'b1;
      pxlValid   = 1'b1;
      pxlData    = 9'd511;
      step();
      frameStart = 1'b0;
      pxlValid   = 1'b0;
      check("t3 restart wren", 256'(dmem_wren), 256'(1'b0));
      wrCount = 0;
      applyStimulus(784, 0, 1'b0);
      step();
      check("t3 writes", 256'(wrCount), 256'(49));

      $display("[TB] enable drop mid-frame");
      rearm();
      pulseFrameStart();
      wrCount = 0;
      applyStimulus(300, 0, 1'b0);
      enable = 1'b0;
      step();
      check("t4 busy", 256'(busy),     256'(1'b0));
      check("t4 done", 256'(img_done), 256'(1'b0));
      frameStart = 1'b1;
      step();
      frameStart = 1'b0;
      for (int i = 0; i < 20; i++) begin
         pxlValid = 1'b1;
         pxlData  = 9'(i);
         step();
      end
      pxlValid = 1'b0;
      step();
      check("t4 abort writes", 256'(wrCount), 256'(18));
      enable = 1'b1;
      step();
      pulseFrameStart();
      wrCount = 0;
      applyStimulus(784, 0, 1'b0);
      step();
      check("t4 writes", 256'(wrCount), 256'(49));

      $display("[TB] hold in DONE");
      wrCount = 0;
      pulseFrameStart();
      for (int i = 0; i < 50; i++) begin
         pxlValid = 1'b1;
         pxlData  = 9'(i);
         step();
         check("t5 wren", 256'(dmem_wren), 256'(1'b0));
         check("t5 done", 256'(img_done),  256'(1'b1));
      end
      pxlValid = 1'b0;
      step();
      check("t5 writes", 256'(wrCount), 256'(0));
      check("t5 busy",   256'(busy),    256'(1'b0));
      enable = 1'b0;
      step();
      check("t5 done clr", 256'(img_done), 256'(1'b0));
      enable = 1'b1;
      step();
      check("t5 rearm busy", 256'(busy),     256'(1'b1));
      check("t5 rearm done", 256'(img_done), 256'(1'b0));

      $display("[TB] reset during word 10");
      pulseFrameStart();
      applyStimulus(160, 0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6 wren",   256'(dmem_wren),   256'(1'b0));
      check("t6 wraddr", 256'(dmem_wraddr), 256'(0));
      check("t6 wrdata", dmem_wrdata,       256'(0));
      check("t6 done",   256'(img_done),    256'(1'b0));
      check("t6 busy",   256'(busy),        256'(1'b0));
      step();
      rst_n   = 1'b1;
      wrCount = 0;
      step();
      for (int i = 0; i < 40; i++) begin
         pxlValid = 1'b1;
         pxlData  = 9'(i);
         step();
         check("t6 wren", 256'(dmem_wren), 256'(1'b0));
      end
      pxlValid = 1'b0;
      step();
      check("t6 writes",     256'(wrCount), 256'(0));
      check("t6 armed busy", 256'(busy),    256'(1'b1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
